// File: rtl/regfile_monitor_pkg.sv
// Shared types and default sizing for the register-file completion monitor.
package regfile_monitor_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_AW_DEF   = $clog2(NUM_REGS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } mon_state_t;

  typedef struct packed {
    logic                  en;
    logic [REG_AW_DEF-1:0] idx;
    logic [DATA_W_DEF-1:0] val;
  } check_cfg_t;

endpackage

// File: rtl/regfile_check_channel.sv
// One register check: selects the indexed register and compares it with the expected value.
module regfile_check_channel #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] registers_i,
  input  logic                            en_i,
  input  logic [REG_AW-1:0]               idx_i,
  input  logic [DATA_W-1:0]               val_i,
  output logic                            match_o
);

  logic              in_range;
  logic [DATA_W-1:0] rd_val;

  // Only reachable when NUM_REGS is not a power of two.
  assign in_range = (32'(idx_i) < NUM_REGS);

  always_comb begin
    rd_val = '0;
    if (in_range) begin
      rd_val = registers_i[idx_i];
    end
  end

  assign match_o = ~en_i | (in_range & (rd_val == val_i));

endmodule

// File: rtl/regfile_completion_monitor.sv
// Configurable pass/fail checker: waits for all enabled register checks to hold for
// STABLE_CYCLES consecutive cycles, with an optional timeout.
module regfile_completion_monitor
  import regfile_monitor_pkg::*;
#(
  parameter int unsigned NUM_CHECKS    = 4,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned NUM_REGS      = NUM_REGS_DEF,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 2,
  localparam int unsigned REG_AW       = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   registers,
  input  logic                              start,
  input  logic [NUM_CHECKS-1:0]             check_en,
  input  logic [NUM_CHECKS-1:0][REG_AW-1:0] check_idx,
  input  logic [NUM_CHECKS-1:0][DATA_W-1:0] check_val,
  input  logic [CNT_W-1:0]                  timeout_cycles,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timed_out,
  output logic [NUM_CHECKS-1:0]             fail_mask,
  output logic [CNT_W-1:0]                  cycle_count
);

  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  mon_state_t                        state_q;
  logic [NUM_CHECKS-1:0]             en_q;
  logic [NUM_CHECKS-1:0][REG_AW-1:0] idx_q;
  logic [NUM_CHECKS-1:0][DATA_W-1:0] val_q;
  logic [CNT_W-1:0]                  tmo_q;
  logic [CNT_W-1:0]                  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]                  first_idx_q;
  logic [SW-1:0]                     stable_cnt_q, stable_cnt_d;
  logic                              busy_q, done_q, pass_q, timed_out_q;
  logic [NUM_CHECKS-1:0]             fail_mask_q;
  logic [CNT_W-1:0]                  cycle_count_q;

  logic [NUM_CHECKS-1:0] match;
  logic                  all_match;
  logic                  pass_hit;
  logic                  tmo_hit;
  logic [CNT_W-1:0]      pass_idx;

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_chan
    regfile_check_channel #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW)
    ) u_chan (
      .registers_i (registers),
      .en_i        (en_q[i]),
      .idx_i       (idx_q[i]),
      .val_i       (val_q[i]),
      .match_o     (match[i])
    );
  end

  assign all_match    = &match;
  assign pass_hit     = all_match && (stable_cnt_q == SW'(STABLE_CYCLES - 1));
  assign tmo_hit      = (tmo_q != '0) && (run_cnt_q == tmo_q - CNT_W'(1));
  assign run_cnt_d    = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_W'(1);
  assign stable_cnt_d = all_match ? stable_cnt_q + SW'(1) : '0;
  // A window that opens and closes on the same cycle has not captured first_idx yet.
  assign pass_idx     = (stable_cnt_q == '0) ? run_cnt_q : first_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      en_q          <= '0;
      idx_q         <= '0;
      val_q         <= '0;
      tmo_q         <= '0;
      run_cnt_q     <= '0;
      first_idx_q   <= '0;
      stable_cnt_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      fail_mask_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (pass_hit) begin
            state_q       <= PASS;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            pass_q        <= 1'b1;
            cycle_count_q <= pass_idx;
          end else if (tmo_hit) begin
            state_q     <= FAIL;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            timed_out_q <= 1'b1;
            fail_mask_q <= en_q & ~match;
          end else begin
            run_cnt_q    <= run_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            if (all_match && (stable_cnt_q == '0)) begin
              first_idx_q <= run_cnt_q;
            end
          end
        end
        default: begin
          if (start) begin
            state_q       <= RUN;
            en_q          <= check_en;
            idx_q         <= check_idx;
            val_q         <= check_val;
            tmo_q         <= timeout_cycles;
            run_cnt_q     <= '0;
            first_idx_q   <= '0;
            stable_cnt_q  <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            fail_mask_q   <= '0;
            cycle_count_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_mask   = fail_mask_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/regfile_completion_monitor.md
# regfile_completion_monitor

Parametrised, synthesizable completion checker that watches the architectural register file and decides pass/fail for a program run. It compares up to NUM_CHECKS (register index, expected value) pairs against the live register contents and requires every enabled pair to match for STABLE_CYCLES consecutive cycles. It reports the cycle count at first match and enforces a programmable timeout. It binds onto RegisterFile alongside the core and replaces the single hard-wired x2 check with a configurable, restartable checker.

## Interface
- NUM_CHECKS, 4, number of independent register checks
- DATA_W, 32, register width
- NUM_REGS, 32, register file depth; index width REG_AW = $clog2(NUM_REGS)
- CNT_W, 16, cycle counter / timeout width
- STABLE_CYCLES, 2, consecutive all-match cycles required to pass (>=1)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- registers  input  NUM_REGS x DATA_W  live register file contents
- start  input  1  single-cycle pulse: latch configuration, begin run
- check_en  input  NUM_CHECKS  per-check enable
- check_idx  input  NUM_CHECKS x REG_AW  register index per check
- check_val  input  NUM_CHECKS x DATA_W  expected value per check
- timeout_cycles  input  CNT_W  run limit in cycles; 0 = no timeout
- busy  output  1  high in RUN
- done  output  1  high in PASS or FAIL, held until next start
- pass  output  1  high in PASS only
- timed_out  output  1  high in FAIL
- fail_mask  output  NUM_CHECKS  enabled checks not matching at timeout
- cycle_count  output  CNT_W  RUN cycle index of first cycle of the passing window

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset -> IDLE.
- IDLE/PASS/FAIL + start: latch check_en/idx/val/timeout_cycles, clear counters, go RUN. Config inputs are ignored outside that edge.
- RUN + start: ignored.
- Per check i: match[i] = ~en[i] | (registers[idx[i]] == val[i]). all_match = &match. Evaluated combinationally from live registers.
- run_cnt counts RUN cycles from 0 and saturates at all-ones. stable_cnt increments on all_match and clears to 0 on any mismatch cycle. first_idx captures run_cnt on the cycle stable_cnt goes 0->1.
- Pass: all_match with stable_cnt == STABLE_CYCLES-1 -> PASS; cycle_count <= first_idx, or run_cnt when STABLE_CYCLES == 1.
- Timeout: timeout_cycles != 0, run_cnt == timeout_cycles-1, and pass not met on the same cycle -> FAIL; fail_mask <= latched en & ~match. Pass wins on the same cycle.
- Any latched index >= NUM_REGS is a mismatch for that check.
- All enables zero: all_match is constant 1, so the run passes after STABLE_CYCLES cycles with cycle_count 0.

## Timing
- Reset values: busy 0, done 0, pass 0, timed_out 0, fail_mask 0, cycle_count 0. All internal counters are 0.
- Reset mid-RUN returns to IDLE asynchronously, and all outputs return to reset values.
- start at edge t: busy is high from t+1, and RUN cycle 0 is the cycle after t.
- A register value first present in RUN cycle k and held: done/pass rise at the edge ending cycle k+STABLE_CYCLES-1, with cycle_count = k.
- Timeout T: if no pass occurs, done/timed_out rise at the edge ending RUN cycle T-1. busy is high for exactly T cycles.
- fail_mask and cycle_count change only on entry to PASS/FAIL, and are cleared on start.
- No combinational path from registers to any output.

## Structure
- Package regfile_monitor_pkg holds:
  - mon_state_t enum {IDLE, RUN, PASS, FAIL}
  - a check_cfg_t struct {en, idx, val}, sized from package constants DATA_W_DEF and NUM_REGS_DEF
- Sub-module regfile_check_channel holds the index mux, range check and compare for one check, producing match. It is instantiated NUM_CHECKS times in a generate loop.
- Top level holds the FSM, counters and output registers.

## Test plan
- x2 reaches 0x40 at RUN cycle 20, check {en0, idx 2, val 0x40}, STABLE_CYCLES 2, timeout 600 -> pass, cycle_count 20, done at the edge ending cycle 21.
- x2 pulses 0x40 for 1 cycle only, then reaches 0x40 for good at cycle 30 -> stable_cnt resets, cycle_count 30.
- Checks x1 == 3 and x2 == 6, x2 never reaches 6, timeout 50 -> FAIL at the edge ending cycle 49, fail_mask 0b0010, busy high for 50 cycles.
- Pass condition completes on exactly cycle timeout-1 -> PASS, timed_out 0.
- start with check_en 0 -> PASS after STABLE_CYCLES cycles, cycle_count 0. A second start during RUN is ignored. start after PASS restarts with outputs cleared.
- rst asserted mid-RUN, between clock edges -> outputs 0 immediately. Then start -> a fresh run with cycle_count measured from the new start.
